// File: rtl/logic_gate_unit.sv
// Purpose : WIDTH-bit multi-function bitwise/reduction gate unit with a 2-entry result buffer.
// Latency : 1 cycle from accept to out_valid when the buffer is empty.
// Backpr. : in_ready is registered and drops only when both buffer entries are occupied.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset (deassertion assumed synchronous to clk)
//   in_valid/in_ready   upstream handshake; in_a, in_b, in_op, in_red sampled on accept
//   out_valid/out_ready downstream handshake; out_y is the head-of-buffer result
//   out_cnt             count of results consumed downstream, wraps modulo 2^CNT_W
//   out_par             (only with LOGIC_GATE_UNIT_PARITY_EN) even parity of out_y
//
// Optional feature macro: LOGIC_GATE_UNIT_PARITY_EN

module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_red,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [CNT_W-1:0] out_cnt
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    ,
    output logic             out_par
`endif
);

    // Opcode encoding shared by bitwise and reduction modes.
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // One buffered result. Parity is kept next to the result so the output
    // never has to recompute it from a register that may be changing.
    typedef struct packed {
`ifdef LOGIC_GATE_UNIT_PARITY_EN
        logic             par;
`endif
        logic [WIDTH-1:0] y;
    } entry_t;

    // ------------------------------------------------------------------
    // Result computation (only meaningful on the accept edge)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] result;
    entry_t           result_e;

    always_comb begin
        result = '0;
        if (in_red) begin
            // Reduction mode: single-bit answer in bit 0, upper bits stay zero.
            case (in_op)
                OP_AND:  result[0] = &in_a;
                OP_OR:   result[0] = |in_a;
                OP_XOR:  result[0] = ^in_a;
                OP_NAND: result[0] = ~&in_a;
                OP_NOR:  result[0] = ~|in_a;
                OP_XNOR: result[0] = ~^in_a;
                OP_NOTA: result[0] = ~in_a[0];
                OP_PASS: result[0] = in_a[0];
                default: result[0] = 1'b0;
            endcase
        end else begin
            case (in_op)
                OP_AND:  result = in_a & in_b;
                OP_OR:   result = in_a | in_b;
                OP_XOR:  result = in_a ^ in_b;
                OP_NAND: result = ~(in_a & in_b);
                OP_NOR:  result = ~(in_a | in_b);
                OP_XNOR: result = ~(in_a ^ in_b);
                OP_NOTA: result = ~in_a;
                OP_PASS: result = in_a;
                default: result = '0;
            endcase
        end
    end

    always_comb begin
        result_e   = '0;
        result_e.y = result;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
        result_e.par = ^result;
`endif
    end

    // ------------------------------------------------------------------
    // Two-entry buffer: a head register that drives the outputs directly
    // and a skid register behind it. The head keeps its contents when it
    // empties, so out_y holds the last delivered value.
    // ------------------------------------------------------------------
    entry_t           head_q, head_d;
    logic             head_vld_q, head_vld_d;
    entry_t           skid_q, skid_d;
    logic             skid_vld_q, skid_vld_d;
    logic             in_rdy_q, in_rdy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic push;
    logic pop;

    // in_rdy_q mirrors (occupancy < 2) of the current state, so a pop while
    // full frees the slot only from the next cycle.
    assign push = in_valid & in_rdy_q;
    assign pop  = head_vld_q & out_ready;

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        cnt_d      = cnt_q;

        if (pop) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (skid_vld_q) begin
                // Full: push cannot happen this cycle, skid moves up.
                head_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (push) begin
                // Occupancy 1 with push and pop: new entry becomes the head.
                head_d = result_e;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_d     = result_e;
                head_vld_d = 1'b1;
            end else begin
                skid_d     = result_e;
                skid_vld_d = 1'b1;
            end
        end

        in_rdy_d = ~(head_vld_d & skid_vld_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            head_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b1;
            cnt_q      <= '0;
        end else begin
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= in_rdy_d;
            cnt_q      <= cnt_d;
        end
    end

    // All outputs come straight from registers.
    assign in_ready  = in_rdy_q;
    assign out_valid = head_vld_q;
    assign out_y     = head_q.y;
    assign out_cnt   = cnt_q;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    assign out_par   = head_q.par;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Purpose : self-checking bench for logic_gate_unit (WIDTH=8, CNT_W=4).
// Latency : cycle-driven; inputs change on the falling edge, outputs sampled 1 time unit later.
// Backpr. : out_ready is driven by directed sequences and by random stimulus.

module tb_logic_gate_unit;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         in_red;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic [C-1:0] out_cnt;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    logic         out_par;
`endif

    logic_gate_unit #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_red    (in_red),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_cnt   (out_cnt)
`ifdef LOGIC_GATE_UNIT_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pending results in order, consumed count, last delivered value.
    logic [W-1:0] model_q[$];
    int           model_cnt;
    logic [W-1:0] model_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Truth tables indexed by {a_bit, b_bit}.
    function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op, input logic red);
        logic [3:0] tt[8];
        logic [W-1:0] y;
        int ones;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
        tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
        y = '0;
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(a[i]);
        if (red) begin
            case (op)
                3'd0: y[0] = (ones == W);
                3'd1: y[0] = (ones != 0);
                3'd2: y[0] = (ones % 2 == 1);
                3'd3: y[0] = (ones != W);
                3'd4: y[0] = (ones == 0);
                3'd5: y[0] = (ones % 2 == 0);
                3'd6: y[0] = !a[0];
                default: y[0] = a[0];
            endcase
        end else begin
            for (int i = 0; i < W; i++) y[i] = tt[op][{a[i], b[i]}];
        end
        return y;
    endfunction

    function automatic logic par_of(input logic [W-1:0] v);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(v[i]);
        return logic'(ones % 2);
    endfunction

    task automatic model_reset();
        model_q.delete();
        model_cnt  = 0;
        model_last = '0;
    endtask

    // One clock cycle starting at a falling edge: drive, compare, advance model at the rising edge.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic red, input logic ordy);
        logic push, pop;
        logic [W-1:0] res;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_red    = red;
        out_ready = ordy;
        #1;
        chk("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
        chk("out_cnt", 64'(out_cnt), 64'(model_cnt));
        if (model_q.size() > 0) begin
            chk("out_y", 64'(out_y), 64'(model_q[0]));
`ifdef LOGIC_GATE_UNIT_PARITY_EN
            chk("out_par", 64'(out_par), 64'(par_of(model_q[0])));
`endif
        end else begin
            chk("out_y_hold", 64'(out_y), 64'(model_last));
        end
        push = v && (model_q.size() < 2);
        pop  = ordy && (model_q.size() > 0);
        res  = ref_y(a, b, op, red);
        @(posedge clk);
        if (pop) begin
            model_last = model_q.pop_front();
            model_cnt  = (model_cnt + 1) % (1 << C);
        end
        if (push) model_q.push_back(res);
        @(negedge clk);
    endtask

    logic [W-1:0] tt_exp[8];

    initial begin
        tt_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_red = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_y", 64'(out_y), 64'd0);
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        rst_n = 1'b1;

        // Truth table with a streaming consumer: each result is head one cycle after accept.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b0, 1'b1);
            #1;
            chk("tt_y", 64'(out_y), 64'(tt_exp[i]));
            chk("tt_vld", 64'(out_valid), 64'd1);
        end

        // Reduction mode.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'hFF, 8'h00, 3'(i), 1'b1, 1'b1);
            #1;
            chk("red_ff", 64'(out_y), (i < 2) ? 64'd1 : 64'd0);
        end
        cycle(1'b1, 8'h01, 8'hFF, 3'd2, 1'b1, 1'b1);
        #1;
        chk("red_xor01", 64'(out_y), 64'h01);

        // Drain, then backpressure: three offers, two accepted.
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        cycle(1'b1, 8'hA5, 8'h0F, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 8'h0F, 3'd1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 8'h0F, 3'd2, 1'b0, 1'b0);
        #1;
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(out_y), 64'h05);
        // Pop one while full: in_ready stays low that cycle, rises the next.
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        #1;
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        chk("bp_order", 64'(out_y), 64'hAF);
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);

        // Continuous streaming: throughput one per cycle, in_ready never drops.
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'b1);
        #1;
        chk("stream_in_ready", 64'(in_ready), 64'd1);
        chk("stream_cnt", 64'(out_cnt), 64'(model_cnt));

        // Asynchronous reset with the buffer full.
        cycle(1'b1, 8'h11, 8'h22, 3'd1, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 8'h44, 3'd1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_cnt", 64'(out_cnt), 64'd0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h5A, 8'h0F, 3'd2, 1'b0, 1'b0);
        #1;
        chk("post_rst_first", 64'(out_y), 64'h55);

        // Counter wrap: 17 pops on a 4-bit counter.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++)
            cycle(1'b1, 8'(i), 8'hFF, 3'd7, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        #1;
        chk("cnt_wrap", 64'(out_cnt), 64'd1);

`ifdef LOGIC_GATE_UNIT_PARITY_EN
        cycle(1'b1, 8'h07, 8'h00, 3'd7, 1'b0, 1'b1);
        #1;
        chk("par_07", 64'(out_par), 64'd1);
`endif

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 2000; i++)
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        #1;
        chk("final_empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
Name:
logic_gate_unit

Overview:
- Parametrised successor to the single-bit 2-input gates: a WIDTH-bit multi-function bitwise gate unit with per-transaction opcode select and a reduction mode.
- Registered result with valid/ready handshakes on both sides and a 2-entry output buffer, so upstream and downstream stalls are decoupled.
- Sits as a reusable datapath primitive between streaming producers and consumers in the basic-gates library.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1 to 64).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a transaction.
- in_ready  output  1  unit can accept this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 PASS A.
- in_red  input  1  1 = reduction mode (operand B ignored).
- out_valid  output  1  result available at head of buffer.
- out_ready  input  1  downstream accepts the result.
- out_y  output  WIDTH  result.
- out_cnt  output  CNT_W  number of results consumed downstream.

Behaviour:
- Reset (rst_n low, asynchronous): buffer emptied; out_valid=0, in_ready=1, out_y=0, out_cnt=0. An in-flight transaction is discarded. Reset release is synchronised to clk.
- Accept: push occurs when in_valid & in_ready at a rising edge. Operands, opcode and in_red are sampled only on that edge.
- Pop: occurs when out_valid & out_ready at a rising edge.
- Bitwise mode (in_red=0): out_y = in_a op in_b, evaluated per bit. NOT and PASS ignore in_b.
- Reduction mode (in_red=1): out_y[0] is one of &a, |a, ^a, ~&a, ~|a, ~^a, ~a[0], a[0] for opcodes 0 to 7. out_y[WIDTH-1:1] = 0.
- The result is computed at accept time and stored in the buffer. Operands are not stored.
- Latency: a result accepted at edge k is visible with out_valid=1 in the cycle after edge k, provided the buffer was empty.
- Buffer: 2 entries, strict FIFO order. occupancy count is 0, 1 or 2.
- in_ready = (occupancy < 2). in_ready is registered: when full, in_ready=0 even if a pop happens in the same cycle. The freed slot is usable from the next cycle.
- Empty: out_valid=0 and out_y holds its last value (0 after reset). Simultaneous push and pop on an empty buffer does not occur, because out_valid=0.
- Occupancy 1: simultaneous push and pop leaves occupancy at 1. The new entry becomes the head on the next cycle.
- Handshake stability: while out_valid=1 and out_ready=0, out_y and out_valid hold stable.
- out_cnt increments by 1 on each pop. It wraps modulo 2^CNT_W, so 2^CNT_W-1 rolls to 0.
- No combinational path from out_ready to in_ready, or from in_* to out_*.

Optional Feature:
- Macro: LOGIC_GATE_UNIT_PARITY_EN.
- Defined: adds output port out_par (1 bit) = ^out_y (even parity) for the head entry. It is stored alongside the entry and is 0 at reset.
- Undefined: no out_par port and no parity storage. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with occupancy 2 -> immediately out_valid=0, in_ready=1, out_cnt=0. The next accepted result is the first one output.
- Truth table, WIDTH=8, out_ready=1: a=8'hF0, b=8'hCC, ops 0-7 -> 8'hC0, FC, 3C, 3F, 03, C3, 0F, F0, each appearing one cycle after its accept.
- Reduction: a=8'hFF, ops 0/1/2/3 -> out_y=1, 1, 0, 0. a=8'h01, op 2 -> out_y=1 with bits [7:1]=0.
- Backpressure: hold out_ready=0 and offer 3 transactions -> 2 are accepted and in_ready=0. Release out_ready=1 for one cycle -> head popped, in_ready returns to 1 on the following cycle, order is preserved.
- Simultaneous push and pop at occupancy 1 with continuous streaming -> occupancy stays at 1 and throughput is one result per cycle.
- Counter wrap, CNT_W=4: 17 pops -> out_cnt=1. With LOGIC_GATE_UNIT_PARITY_EN defined, out_y=8'h07 gives out_par=1.
